// File: rtl/mul_seq_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mul_seq_ctrl_pkg
//   Shared definitions for the sequential RV32M multiplier controller:
//   funct3 encodings, the controller state enum, the default data width,
//   and helpers that say which operands are treated as signed.
// ----------------------------------------------------------------------------
package mul_seq_ctrl_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [2:0] MUL_F3    = 3'b000;
   localparam logic [2:0] MULH_F3   = 3'b001;
   localparam logic [2:0] MULHSU_F3 = 3'b010;
   localparam logic [2:0] MULHU_F3  = 3'b011;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CALC   = 3'd1,
      NEG_LO = 3'd2,
      NEG_HI = 3'd3,
      DONE   = 3'd4
   } state_t;

   // rs1 is signed for MULH and MULHSU; any 1xx code behaves as MULHU.
   function automatic logic rs1_is_signed(input logic [2:0] f3);
      return (f3 == MULH_F3) || (f3 == MULHSU_F3);
   endfunction

   // rs2 is signed for MULH only.
   function automatic logic rs2_is_signed(input logic [2:0] f3);
      return (f3 == MULH_F3);
   endfunction

endpackage

// File: rtl/mul_seq_ctrl_rca.sv
// ----------------------------------------------------------------------------
// NbitRCA
//   Plain N-bit ripple-carry adder: o_sum = i_a + i_b + i_cin.
//   Ports:
//     i_a, i_b  [N-1:0]  addends
//     i_cin              carry in
//     o_sum     [N-1:0]  sum
//     o_cout             carry out of the top bit
// ----------------------------------------------------------------------------
module NbitRCA #(
   parameter int N = 32
) (
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   input  logic         i_cin,
   output logic [N-1:0] o_sum,
   output logic         o_cout
);

   logic [N:0] w_c;

   assign w_c[0] = i_cin;

   for (genvar gi = 0; gi < N; gi++) begin : g_bit
      assign o_sum[gi]  = i_a[gi] ^ i_b[gi] ^ w_c[gi];
      assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
   end

   assign o_cout = w_c[N];

endmodule

// File: rtl/mul_seq_ctrl.sv
// ----------------------------------------------------------------------------
// mul_seq_ctrl
//   Shift-add multiplier controller for MUL/MULH/MULHSU/MULHU. Operands are
//   reduced to magnitudes on accept, multiplied over XLEN iterations with one
//   shared adder, and the 2*XLEN-bit product is negated in two extra cycles
//   when exactly one signed operand was negative.
//   Ports:
//     clk, rst_n         clock, asynchronous active-low reset
//     start              request, accepted only while busy=0 (IDLE or DONE)
//     funct3 [2:0]       operation select (1xx behaves as MULHU)
//     rs1, rs2 [XLEN]    operands, sampled on the accept cycle only
//     busy               operation in progress (CALC/NEG_LO/NEG_HI)
//     done               one-cycle pulse while result becomes valid
//     result [XLEN]      low (MUL) or high word of the product; held until
//                        the next completed operation
//   Handshake: start is a level request qualified by busy=0; there is no
//   back-pressure on done, the core samples result on the done cycle.
// ----------------------------------------------------------------------------
module mul_seq_ctrl
   import mul_seq_ctrl_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [XLEN-1:0]   r_mcand;
   logic [XLEN-1:0]   r_hi;
   logic [XLEN-1:0]   r_lo;
   logic [XLEN-1:0]   r_result;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_neg;
   logic              r_sel_hi;
   logic              r_c;

   logic              w_accept;
   logic              w_last_iter;
   logic              w_rs1_neg;
   logic              w_rs2_neg;
   logic [XLEN-1:0]   w_rs1_twos;
   logic [XLEN-1:0]   w_rs2_twos;
   logic [XLEN-1:0]   w_rs1_mag;
   logic [XLEN-1:0]   w_rs2_mag;

   logic [XLEN-1:0]   w_add_a;
   logic [XLEN-1:0]   w_add_b;
   logic              w_add_cin;
   logic [XLEN-1:0]   w_sum;
   logic              w_cout;
   logic [XLEN-1:0]   w_hi_nxt;
   logic [XLEN-1:0]   w_lo_nxt;

   assign w_accept    = start && ((r_state == IDLE) || (r_state == DONE));
   assign w_last_iter = (r_cnt == CNT_W'(XLEN - 1));

   // Only operands declared signed by funct3 contribute a sign.
   assign w_rs1_neg = rs1_is_signed(funct3) && rs1[XLEN-1];
   assign w_rs2_neg = rs2_is_signed(funct3) && rs2[XLEN-1];

   // Two's-complement negation (~x + 1) for the operand magnitudes. The most
   // negative value maps onto itself, which is its correct unsigned magnitude.
   NbitRCA #(.N(XLEN)) u_abs_rs1 (
      .i_a    (~rs1),
      .i_b    ('0),
      .i_cin  (1'b1),
      .o_sum  (w_rs1_twos),
      .o_cout ()
   );

   NbitRCA #(.N(XLEN)) u_abs_rs2 (
      .i_a    (~rs2),
      .i_b    ('0),
      .i_cin  (1'b1),
      .o_sum  (w_rs2_twos),
      .o_cout ()
   );

   assign w_rs1_mag = w_rs1_neg ? w_rs1_twos : rs1;
   assign w_rs2_mag = w_rs2_neg ? w_rs2_twos : rs2;

   // Shared adder operand mux. NEG_LO/NEG_HI form ~{hi,lo} + 1 as two
   // XLEN-bit halves, chaining the carry through r_c.
   always_comb begin
      w_add_a   = '0;
      w_add_b   = '0;
      w_add_cin = 1'b0;
      case (r_state)
         CALC: begin
            w_add_a = r_hi;
            w_add_b = r_lo[0] ? r_mcand : '0;
         end
         NEG_LO: begin
            w_add_a   = ~r_lo;
            w_add_cin = 1'b1;
         end
         NEG_HI: begin
            w_add_a   = ~r_hi;
            w_add_cin = r_c;
         end
         default: ;
      endcase
   end

   NbitRCA #(.N(XLEN)) u_add (
      .i_a    (w_add_a),
      .i_b    (w_add_b),
      .i_cin  (w_add_cin),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

   // Next product halves. In CALC the carry-extended partial sum shifts right
   // by one into {hi,lo}, consuming the multiplier bit just used from lo[0].
   always_comb begin
      w_hi_nxt = r_hi;
      w_lo_nxt = r_lo;
      case (r_state)
         CALC: begin
            w_hi_nxt = {w_cout, w_sum[XLEN-1:1]};
            w_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};
         end
         NEG_LO:  w_lo_nxt = w_sum;
         NEG_HI:  w_hi_nxt = w_sum;
         default: ;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = CALC;
         CALC:    if (w_last_iter) w_state_nxt = r_neg ? NEG_LO : DONE;
         NEG_LO:  w_state_nxt = NEG_HI;
         NEG_HI:  w_state_nxt = DONE;
         DONE:    w_state_nxt = w_accept ? CALC : IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_mcand  <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_result <= '0;
         r_cnt    <= '0;
         r_neg    <= 1'b0;
         r_sel_hi <= 1'b0;
         r_c      <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_mcand  <= w_rs1_mag;
            r_lo     <= w_rs2_mag;
            r_hi     <= '0;
            r_cnt    <= '0;
            r_neg    <= w_rs1_neg ^ w_rs2_neg;
            r_sel_hi <= (funct3 != MUL_F3);
         end else begin
            r_hi <= w_hi_nxt;
            r_lo <= w_lo_nxt;
            if (r_state == CALC) r_cnt <= r_cnt + 1'b1;
            if (r_state == NEG_LO) r_c <= w_cout;
         end
         // Capture from the values being written this same edge so the word
         // is final on the done cycle.
         if ((w_state_nxt == DONE) && (r_state != DONE)) begin
            r_result <= r_sel_hi ? w_hi_nxt : w_lo_nxt;
         end
      end
   end

   assign busy   = (r_state == CALC) || (r_state == NEG_LO) || (r_state == NEG_HI);
   assign done   = (r_state == DONE);
   assign result = r_result;

endmodule
